// File: rtl/btc_miner_pkg.sv
// Shared constants and state encoding for the nonce sweep controller and its
// view of the sha256 core register map.
package btc_miner_pkg;

    localparam logic [7:0]  SHA_ADDR_CTRL    = 8'h08;
    localparam logic [7:0]  SHA_ADDR_STATUS  = 8'h09;
    localparam logic [7:0]  SHA_ADDR_BLOCK0  = 8'h10;
    localparam logic [7:0]  SHA_ADDR_DIGEST0 = 8'h20;
    localparam logic [7:0]  SHA_ADDR_DIGEST1 = 8'h21;

    // init bit plus SHA-256 mode select
    localparam logic [31:0] SHA_CTRL_INIT    = 32'h0000_0005;

    localparam logic [3:0]  NONCE_WORD       = 4'd3;
    localparam int          STATUS_VALID_BIT = 1;
    localparam int          POLL_GUARD       = 2;

    typedef enum logic [2:0] {
        IDLE,
        WR_BLOCK,
        WR_CTRL,
        POLL,
        RD_D0,
        RD_D1,
        NEXT,
        DONE
    } sweep_state_t;

endpackage

// File: rtl/btc_hdr_buf.sv
// 16-word block header register file: one synchronous write port and one
// asynchronous read port. Deliberately unreset so contents survive a reset.
module btc_hdr_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         we,
    input  logic [3:0]   waddr,
    input  logic [W-1:0] wdata,
    input  logic [3:0]   raddr,
    output logic [W-1:0] rdata
);

    logic [W-1:0] mem [16];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/nonce_sweep_ctrl.sv
// Sweeps a nonce range through an external sha256 core: writes the header
// block with the nonce patched in, starts the hash, polls, and checks digest.
module nonce_sweep_ctrl
    import btc_miner_pkg::*;
#(
    parameter int BITS     = 32,
    parameter int POLL_MAX = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cfg_we,
    input  logic [3:0]      cfg_addr,
    input  logic [BITS-1:0] cfg_wdata,
    input  logic            start,
    input  logic            abort,
    input  logic [BITS-1:0] nonce_start,
    input  logic [BITS-1:0] nonce_end,
    input  logic [BITS-1:0] target,
    output logic            sha_cs,
    output logic            sha_we,
    output logic [7:0]      sha_address,
    output logic [BITS-1:0] sha_write_data,
    input  logic [BITS-1:0] sha_read_data,
    output logic            busy,
    output logic            done,
    output logic            found,
    output logic            aborted,
    output logic            timeout,
    output logic [BITS-1:0] found_nonce,
    output logic [BITS-1:0] cur_nonce
);

    localparam int PW = (POLL_MAX > 1) ? $clog2(POLL_MAX + 1) : 1;

    sweep_state_t    state_reg, state_next;
    logic [3:0]      idx_reg, idx_next;
    logic [PW-1:0]   poll_reg, poll_next;
    logic            z_reg, z_next;
    logic [BITS-1:0] cur_reg, cur_next;
    logic [BITS-1:0] found_nonce_reg, found_nonce_next;
    logic            found_reg, found_next;
    logic            aborted_reg, aborted_next;
    logic            timeout_reg, timeout_next;
    logic [BITS-1:0] hdr_word;

    assign busy = (state_reg != IDLE) && (state_reg != DONE);

    btc_hdr_buf #(.W(BITS)) u_hdr_buf (
        .clk   (clk),
        .we    (cfg_we && !busy),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .raddr (idx_reg),
        .rdata (hdr_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            idx_reg         <= '0;
            poll_reg        <= '0;
            z_reg           <= 1'b0;
            cur_reg         <= '0;
            found_nonce_reg <= '0;
            found_reg       <= 1'b0;
            aborted_reg     <= 1'b0;
            timeout_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            poll_reg        <= poll_next;
            z_reg           <= z_next;
            cur_reg         <= cur_next;
            found_nonce_reg <= found_nonce_next;
            found_reg       <= found_next;
            aborted_reg     <= aborted_next;
            timeout_reg     <= timeout_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        idx_next         = idx_reg;
        poll_next        = poll_reg;
        z_next           = z_reg;
        cur_next         = cur_reg;
        found_nonce_next = found_nonce_reg;
        found_next       = found_reg;
        aborted_next     = aborted_reg;
        timeout_next     = timeout_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    cur_next         = nonce_start;
                    found_next       = 1'b0;
                    found_nonce_next = '0;
                    aborted_next     = 1'b0;
                    timeout_next     = 1'b0;
                    idx_next         = '0;
                    state_next       = WR_BLOCK;
                end
            end
            WR_BLOCK: begin
                idx_next = idx_reg + 4'd1;
                if (idx_reg == 4'd15) begin
                    state_next = WR_CTRL;
                end
            end
            WR_CTRL: begin
                poll_next  = '0;
                state_next = POLL;
            end
            POLL: begin
                poll_next = poll_reg + PW'(1);
                // The first polls may still see the previous hash's valid bit.
                if ((poll_reg >= PW'(POLL_GUARD)) && sha_read_data[STATUS_VALID_BIT]) begin
                    state_next = RD_D0;
                end else if (poll_reg == PW'(POLL_MAX - 1)) begin
                    timeout_next = 1'b1;
                    state_next   = DONE;
                end
            end
            RD_D0: begin
                z_next     = (sha_read_data == '0);
                state_next = RD_D1;
            end
            RD_D1: begin
                if (z_reg && (sha_read_data <= target)) begin
                    found_next       = 1'b1;
                    found_nonce_next = cur_reg;
                    state_next       = DONE;
                end else begin
                    state_next = NEXT;
                end
            end
            NEXT: begin
                if (cur_reg == nonce_end) begin
                    state_next = DONE;
                end else begin
                    cur_next   = cur_reg + BITS'(1);
                    idx_next   = '0;
                    state_next = WR_BLOCK;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort overrides whatever result the same cycle produced.
        if (busy && abort) begin
            state_next       = DONE;
            aborted_next     = 1'b1;
            found_next       = found_reg;
            found_nonce_next = found_nonce_reg;
            timeout_next     = timeout_reg;
            cur_next         = cur_reg;
        end
    end

    always_comb begin
        sha_cs         = 1'b0;
        sha_we         = 1'b0;
        sha_address    = 8'h00;
        sha_write_data = '0;
        case (state_reg)
            WR_BLOCK: begin
                sha_cs         = 1'b1;
                sha_we         = 1'b1;
                sha_address    = SHA_ADDR_BLOCK0 + {4'd0, idx_reg};
                sha_write_data = (idx_reg == NONCE_WORD) ? cur_reg : hdr_word;
            end
            WR_CTRL: begin
                sha_cs         = 1'b1;
                sha_we         = 1'b1;
                sha_address    = SHA_ADDR_CTRL;
                sha_write_data = BITS'(SHA_CTRL_INIT);
            end
            POLL: begin
                sha_cs      = 1'b1;
                sha_address = SHA_ADDR_STATUS;
            end
            RD_D0: begin
                sha_cs      = 1'b1;
                sha_address = SHA_ADDR_DIGEST0;
            end
            RD_D1: begin
                sha_cs      = 1'b1;
                sha_address = SHA_ADDR_DIGEST1;
            end
            default: begin
                sha_cs = 1'b0;
            end
        endcase
    end

    assign done        = (state_reg == DONE);
    assign found       = found_reg;
    assign aborted     = aborted_reg;
    assign timeout     = timeout_reg;
    assign found_nonce = found_nonce_reg;
    assign cur_nonce   = cur_reg;

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Bench for nonce_sweep_ctrl: sha256 register stub, a sweep-level expectation
// model (bus write stream and final result), and directed sweeps.
module tb_nonce_sweep_ctrl;

    localparam int BITS     = 32;
    localparam int POLL_MAX = 255;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            cfg_we = 1'b0;
    logic [3:0]      cfg_addr = '0;
    logic [31:0]     cfg_wdata = '0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [31:0]     nonce_start = '0;
    logic [31:0]     nonce_end = '0;
    logic [31:0]     target = '0;
    logic            sha_cs, sha_we;
    logic [7:0]      sha_address;
    logic [31:0]     sha_write_data;
    logic [31:0]     sha_read_data;
    logic            busy, done, found, aborted, timeout;
    logic [31:0]     found_nonce, cur_nonce;

    always #5 clk = ~clk;

    nonce_sweep_ctrl #(.BITS(BITS), .POLL_MAX(POLL_MAX)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .start          (start),
        .abort          (abort),
        .nonce_start    (nonce_start),
        .nonce_end      (nonce_end),
        .target         (target),
        .sha_cs         (sha_cs),
        .sha_we         (sha_we),
        .sha_address    (sha_address),
        .sha_write_data (sha_write_data),
        .sha_read_data  (sha_read_data),
        .busy           (busy),
        .done           (done),
        .found          (found),
        .aborted        (aborted),
        .timeout        (timeout),
        .found_nonce    (found_nonce),
        .cur_nonce      (cur_nonce)
    );

    // sha256 stub: valid 66 cycles after init; digest hit only for word3 == 5
    logic [31:0] stub_w3 = '0;
    int          stub_since = 0;
    logic        stub_armed = 1'b0;
    logic        stub_dead = 1'b0;

    always @(posedge clk) begin
        if (sha_cs && sha_we && sha_address == 8'h13) stub_w3 <= sha_write_data;
        if (sha_cs && sha_we && sha_address == 8'h08) begin
            stub_since <= 0;
            stub_armed <= 1'b1;
        end else if (stub_armed && stub_since < 1000) begin
            stub_since <= stub_since + 1;
        end
    end

    always_comb begin
        sha_read_data = '0;
        if (sha_cs && !sha_we) begin
            case (sha_address)
                8'h09: sha_read_data = {30'd0, (stub_armed && !stub_dead && stub_since >= 66), 1'b0};
                8'h20: sha_read_data = (stub_w3 == 32'd5) ? 32'h0 : 32'hFFFF_FFFF;
                8'h21: sha_read_data = (stub_w3 == 32'd5) ? 32'h1000 : 32'hFFFF_FFFF;
                default: sha_read_data = '0;
            endcase
        end
    end

    logic [31:0] hdr [16];
    logic [39:0] exp_q [$];
    logic [31:0] w13_q [$];
    logic        exp_found, exp_aborted, exp_timeout;
    logic [31:0] exp_fn, exp_cur;
    int          exp_hashes;
    int          vectors = 0;
    int          miscompares = 0;
    int          done_cnt = 0;
    int          ctrl_cnt = 0;
    int          poll_cnt = 0;
    logic        prev_done = 1'b0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Expected bus write stream and end result of one sweep, from the nonce
    // range rules and the stub's hit rule.
    task automatic build_model(input logic [31:0] s, input logic [31:0] e,
                               input logic [31:0] t, input int max_hashes);
        logic [31:0] n;
        bit          stop;
        int          h;
        exp_q.delete();
        n = s; h = 0; stop = 0;
        exp_found = 1'b0; exp_fn = '0; exp_aborted = 1'b0; exp_timeout = 1'b0;
        exp_cur = s;
        while (!stop) begin
            for (int i = 0; i < 16; i++)
                exp_q.push_back({8'h10 + 8'(i), (i == 3) ? n : hdr[i]});
            exp_q.push_back({8'h08, 32'h5});
            h++;
            exp_cur = n;
            if (!stub_dead && n == 32'd5 && t >= 32'h1000) begin
                exp_found = 1'b1; exp_fn = n; stop = 1;
            end else if (n == e || h >= max_hashes) begin
                stop = 1;
            end else begin
                n = n + 32'd1;
            end
        end
        exp_hashes = h;
    endtask

    task automatic monitor();
        logic [39:0] e;
        forever begin
            @(negedge clk);
            if (sha_cs && sha_we) begin
                if (sha_address == 8'h08) ctrl_cnt++;
                if (sha_address == 8'h13) w13_q.push_back(sha_write_data);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got %0h:%0h, required none", sha_address, sha_write_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("bus_write", {8'd0, sha_address, sha_write_data}, {8'd0, e});
                end
            end
            if (sha_cs && !sha_we && sha_address == 8'h09) poll_cnt++;
            if (!busy)
                chk("idle_bus", {6'd0, sha_cs, sha_we, sha_address, sha_write_data}, 48'd0);
            if (done) begin
                chk("done_one_cycle", {47'd0, prev_done}, 48'd0);
                chk("found", {47'd0, found}, {47'd0, exp_found});
                chk("found_nonce", {16'd0, found_nonce}, {16'd0, exp_fn});
                chk("cur_nonce", {16'd0, cur_nonce}, {16'd0, exp_cur});
                chk("aborted", {47'd0, aborted}, {47'd0, exp_aborted});
                chk("timeout", {47'd0, timeout}, {47'd0, exp_timeout});
                chk("pending_writes", 48'(exp_q.size()), 48'd0);
                done_cnt++;
            end
            prev_done = done;
        end
    endtask

    task automatic run_sweep(input logic [31:0] s, input logic [31:0] e, input logic [31:0] t,
                             input bit poke_cfg, output int polls, output int ctrls);
        int d0, p0, c0;
        bit got;
        nonce_start = s; nonce_end = e; target = t;
        d0 = done_cnt; p0 = poll_cnt; c0 = ctrl_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(negedge clk);
            if (poke_cfg && k == 5) begin
                cfg_we = 1'b1; cfg_addr = 4'd2; cfg_wdata = 32'hDEAD_BEEF;
            end else begin
                cfg_we = 1'b0;
            end
            if (done_cnt != d0) got = 1;
        end
        cfg_we = 1'b0;
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL sweep_timeout: got no done within 3000 cycles, required done");
        end
        polls = poll_cnt - p0;
        ctrls = ctrl_cnt - c0;
    endtask

    initial begin
        int polls, ctrls, n;
        logic [31:0] wrap_exp [4];
        for (int i = 0; i < 16; i++) hdr[i] = 32'hA500_0000 + 32'h0101_0101 * i;
        wrap_exp[0] = 32'hFFFF_FFFE; wrap_exp[1] = 32'hFFFF_FFFF;
        wrap_exp[2] = 32'h0; wrap_exp[3] = 32'h1;

        // reset state
        #12;
        chk("reset_flags", {41'd0, busy, done, found, aborted, timeout, sha_cs, sha_we}, 48'd0);
        chk("reset_bus", {8'd0, sha_address, sha_write_data}, 48'd0);
        chk("reset_nonces", {16'd0, cur_nonce}, 48'd0);
        chk("reset_found_nonce", {16'd0, found_nonce}, 48'd0);
        @(negedge clk);
        reset_n = 1'b1;
        fork
            monitor();
        join_none

        for (int i = 0; i < 16; i++) begin
            cfg_we = 1'b1; cfg_addr = 4'(i); cfg_wdata = hdr[i];
            @(negedge clk);
        end
        cfg_we = 1'b0;
        @(negedge clk);

        // hit at nonce 5 inside 0..10
        build_model(32'd0, 32'd10, 32'h2000, 100);
        chk("model_hashes_hit", 48'(exp_hashes), 48'd6);
        run_sweep(32'd0, 32'd10, 32'h2000, 0, polls, ctrls);
        chk("hit_found_nonce", {16'd0, found_nonce}, 48'd5);
        chk("hit_hashes", 48'(ctrls), 48'd6);
        chk("hit_found", {47'd0, found}, 48'd1);
        repeat (3) @(negedge clk);

        // no hit inside 0..3
        build_model(32'd0, 32'd3, 32'h2000, 100);
        run_sweep(32'd0, 32'd3, 32'h2000, 0, polls, ctrls);
        chk("miss_cur_nonce", {16'd0, cur_nonce}, 48'd3);
        chk("miss_ctrl_writes", 48'(ctrls), 48'd4);
        chk("miss_found", {47'd0, found}, 48'd0);
        repeat (3) @(negedge clk);

        // wrap-around through all-ones
        build_model(32'hFFFF_FFFE, 32'd1, 32'h2000, 100);
        w13_q.delete();
        run_sweep(32'hFFFF_FFFE, 32'd1, 32'h2000, 0, polls, ctrls);
        chk("wrap_count", 48'(w13_q.size()), 48'd4);
        n = (w13_q.size() < 4) ? w13_q.size() : 4;
        for (int i = 0; i < n; i++)
            chk("wrap_nonce", {16'd0, w13_q[i]}, {16'd0, wrap_exp[i]});
        repeat (3) @(negedge clk);

        // abort during 3rd POLL cycle of the first hash
        build_model(32'd0, 32'd10, 32'h2000, 1);
        exp_aborted = 1'b1;
        nonce_start = 32'd0; nonce_end = 32'd10; target = 32'h2000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int k = 0; k < 200 && n < 3; k++) begin
            if (sha_cs && !sha_we && sha_address == 8'h09) n++;
            if (n < 3) @(negedge clk);
        end
        chk("abort_reached_poll3", 48'(n), 48'd3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_flag", {47'd0, aborted}, 48'd1);
        chk("abort_cs", {47'd0, sha_cs}, 48'd0);
        chk("abort_done", {47'd0, done}, 48'd1);
        repeat (5) @(negedge clk);
        build_model(32'd3, 32'd6, 32'h2000, 100);
        run_sweep(32'd3, 32'd6, 32'h2000, 0, polls, ctrls);
        chk("post_abort_found_nonce", {16'd0, found_nonce}, 48'd5);
        chk("post_abort_aborted", {47'd0, aborted}, 48'd0);
        repeat (3) @(negedge clk);

        // status never valid -> timeout; cfg write mid-sweep must be ignored
        stub_dead = 1'b1;
        build_model(32'd7, 32'd9, 32'h2000, 1);
        exp_timeout = 1'b1;
        run_sweep(32'd7, 32'd9, 32'h2000, 1, polls, ctrls);
        chk("timeout_polls", 48'(polls), 48'd255);
        chk("timeout_flag", {47'd0, timeout}, 48'd1);
        stub_dead = 1'b0;
        repeat (3) @(negedge clk);

        // single-nonce range; block stream proves header word 2 unchanged
        build_model(32'd5, 32'd5, 32'h2000, 100);
        run_sweep(32'd5, 32'd5, 32'h2000, 0, polls, ctrls);
        chk("single_hashes", 48'(ctrls), 48'd1);
        chk("single_found", {47'd0, found}, 48'd1);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nonce_sweep_ctrl.md
NONCE_SWEEP_CTRL -- requirements
Module: nonce_sweep_ctrl

Interface
REQ-001 SHALL have parameters: BITS, default 32, data word width; POLL_MAX, default 255, max status-poll cycles before timeout.
REQ-002 SHALL use one clock; reset is asynchronous and active-low. Ports: clk (in, 1, rising-edge clock); reset_n (in, 1, async active-low reset).
REQ-003 SHALL have cfg_we (in, 1, header-word write strobe); cfg_addr (in, 4, header word index 0-15); cfg_wdata (in, BITS, header word).
REQ-004 SHALL have start (in, 1, begin sweep pulse); abort (in, 1, stop sweep); nonce_start and nonce_end (in, BITS each, inclusive range); target (in, BITS, hit threshold).
REQ-005 SHALL have sha_cs, sha_we (out, 1 each); sha_address (out, 8); sha_write_data (out, BITS); sha_read_data (in, BITS). These form the sha256 register port; read data is combinational, valid in the same cycle as cs=1, we=0.
REQ-006 SHALL have busy, done, found, aborted, timeout (out, 1 each); found_nonce and cur_nonce (out, BITS each).

Function
REQ-007 SHALL hold a 16x32 header buffer; cfg_we writes cfg_wdata to word cfg_addr when not busy; cfg_we while busy is ignored.
REQ-008 SHALL use states IDLE, WR_BLOCK, WR_CTRL, POLL, RD_D0, RD_D1, NEXT, DONE.
REQ-009 IDLE: start=1 loads cur_nonce=nonce_start, clears done/found/aborted/timeout, and enters WR_BLOCK; start while busy is ignored.
REQ-010 WR_BLOCK: 16 cycles, word index i=0..15; cs=1, we=1, address=0x10+i; write_data=cur_nonce when i=3, otherwise buf[i]; after i=15 enters WR_CTRL.
REQ-011 WR_CTRL: 1 cycle; cs=1, we=1, address=0x08, write_data=0x5 (init, SHA-256 mode); then enters POLL.
REQ-012 POLL: cs=1, we=0, address=0x09. Status is ignored for the first 2 POLL cycles (stale-valid guard). Afterwards read_data[1]=1 enters RD_D0.
REQ-013 POLL cycle counter reaching POLL_MAX without valid: sets timeout=1 and enters DONE.
REQ-014 RD_D0: 1 cycle reading address 0x20; latches z = (read_data==0). RD_D1: 1 cycle reading address 0x21. Hit = z AND read_data <= target (unsigned).
REQ-015 On hit: found=1, found_nonce=cur_nonce, enter DONE. Otherwise go to NEXT.
REQ-016 NEXT: if cur_nonce==nonce_end, enter DONE with found=0; else cur_nonce+1 modulo 2^BITS and re-enter WR_BLOCK.
REQ-017 Wrap-around: if nonce_start > nonce_end, the sweep passes through 0xFFFFFFFF to 0. If nonce_start==nonce_end, exactly one hash is computed.
REQ-018 abort=1 in any busy state: next cycle enters DONE with aborted=1 and sha_cs=0. abort has priority over a hit or end detected in the same cycle.
REQ-019 DONE: done=1 for exactly 1 cycle, then IDLE. found, found_nonce, aborted and timeout hold until the next start.
REQ-020 busy=1 in every state except IDLE and DONE. In IDLE and DONE, sha_cs=0, sha_we=0, address=0, write_data=0.
REQ-021 sha_* outputs SHALL be decoded from the state and index registers (Moore), with no combinational path from sha_read_data.

Reset
REQ-022 reset_n=0 SHALL asynchronously force: state=IDLE, all counters 0, cur_nonce=0, found_nonce=0, all flags 0, all sha_* outputs 0.
REQ-023 Reset mid-sweep SHALL abandon the sweep with no done pulse; header buffer contents are preserved.

Structure
REQ-024 Package btc_miner_pkg SHALL hold the sha256 address constants (CTRL 0x08, STATUS 0x09, BLOCK0 0x10, DIGEST0 0x20), the ctrl word 0x5, the nonce word index 3, and the state enum.
REQ-025 The header buffer SHALL be the sub-module btc_hdr_buf: a 16x32 register file with 1 write port and 1 async read port, not reset.

Verification (bench uses a behavioural sha256 stub: valid 66 cycles after init; digest0=0 and digest1=0x1000 only when block word 3 = 0x5, else digest0=0xFFFFFFFF)
REQ-026 start=0, end=10, target=0x2000 -> found=1, found_nonce=5, done pulse, 6 hashes observed.
REQ-027 start=0, end=3, target=0x2000 -> done with found=0, cur_nonce=3, exactly 4 WR_CTRL writes of 0x5.
REQ-028 start=0xFFFFFFFE, end=1 -> nonces 0xFFFFFFFE, 0xFFFFFFFF, 0, 1 written to address 0x13, then found=0.
REQ-029 abort asserted during the 3rd POLL -> next cycle aborted=1, sha_cs=0, done pulse; start 5 cycles later runs normally.
REQ-030 stub never asserts valid, POLL_MAX=255 -> timeout=1 after 255 POLL cycles; cfg_we during sweep leaves buffer unchanged.
